// File: rtl/byte_serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract through one SLICE-bit ripple slice per clock.
// Reports RES plus CF/ZF/SF/OF over a valid/ready handshake.
module byte_serial_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RES,
    output logic             CF,
    output logic             ZF,
    output logic             SF,
    output logic             OF
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             cf_q, cf_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;

    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sum;

    // Slice operand select by constant-indexed compare to keep the mux lint-clean.
    always_comb begin
        a_sl = a_q[SLICE-1:0];
        b_sl = b_q[SLICE-1:0];
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CntW'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
        sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{SUB}};
                    sub_d   = SUB;
                    carry_d = SUB;
                    cnt_d   = '0;
                    res_d   = '0;
                    zero_d  = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CntW'(i)) res_d[i*SLICE +: SLICE] = sum[SLICE-1:0];
                end
                carry_d = sum[SLICE];
                cnt_d   = cnt_q + CntW'(1);
                zero_d  = zero_q & ~|sum[SLICE-1:0];
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    cf_d    = sum[SLICE] ^ sub_q;
                    sf_d    = sum[SLICE-1];
                    zf_d    = zero_q & ~|sum[SLICE-1:0];
                    // Equal operand signs with a flipped result sign == cin(MSB) ^ cout(MSB).
                    of_d    = (a_sl[SLICE-1] == b_sl[SLICE-1]) &
                              (sum[SLICE-1] != a_sl[SLICE-1]);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign RES       = res_q;
    assign CF        = cf_q;
    assign ZF        = zf_q;
    assign SF        = sf_q;
    assign OF        = of_q;

endmodule

// File: tb/tb_byte_serial_addsub.sv
// Scoreboard bench for byte_serial_addsub: driver pushes expected results, a negedge
// monitor compares them whenever out_valid is presented.
module tb_byte_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        SUB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] RES;
    logic        CF, ZF, SF, OF;

    byte_serial_addsub #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .SUB       (SUB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RES       (RES),
        .CF        (CF),
        .ZF        (ZF),
        .SF        (SF),
        .OF        (OF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;   // {CF, ZF, SF, OF}
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint last_acc = 0;
    logic   prev_ov  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic [32:0] w;
        logic        ov;
        if (s) w = {1'b0, a} - {1'b0, b};
        else   w = {1'b0, a} + {1'b0, b};
        if (s) ov = (a[31] != b[31]) && (w[31] != a[31]);
        else   ov = (a[31] == b[31]) && (w[31] != a[31]);
        e.res = w[31:0];
        e.fl  = {w[32], (w[31:0] == 32'd0), w[31], ov};
        e.acc = 0;
        return e;
    endfunction

    // Present operands, wait for acceptance, push the expected response.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] er, input logic [3:0] ef, input bit keep,
                         input bit chk_ii);
        exp_t e;
        bit   ok = 0;
        A = a; B = b; SUB = s; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready never rose, expected 1");
            return;
        end
        e.res = er; e.fl = ef; e.acc = cyc + 1;
        if (chk_ii) check("initiation_interval", e.acc - last_acc, 6);
        last_acc = e.acc;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_output: out_valid=1 with RES=0x%0h, expected none", RES);
            end else begin
                e = sb[0];
                if (!prev_ov) check("latency", cyc - e.acc, 4);
                check("res", RES, e.res);
                check("flags_cf_zf_sf_of", {CF, ZF, SF, OF}, e.fl);
                check("in_ready_in_done", in_ready, 0);
                if (out_ready) void'(sb.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        bit   seen_ov;
        logic [31:0] ra, rb;
        logic        rs;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; SUB = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_res", RES, 0);
        check("reset_flags", {CF, ZF, SF, OF}, 0);
        @(negedge clk); rst_n = 1'b1;

        // Reset mid-operation: aborted op must never appear.
        @(posedge clk); #1;
        A = 32'h1234_5678; B = 32'h1111_1111; SUB = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midop_reset_out_valid", out_valid, 0);
        check("midop_reset_res", RES, 0);
        check("midop_reset_flags", {CF, ZF, SF, OF}, 0);
        check("midop_reset_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        seen_ov = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1;
        end
        check("aborted_op_no_output", seen_ov, 0);
        check("post_reset_in_ready", in_ready, 1);

        // Directed vectors: flags are {CF, ZF, SF, OF}.
        @(posedge clk); #1;
        issue(32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 4'b0000, 0, 0);
        issue(32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b1010, 0, 0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0011, 0, 0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0001, 0, 0);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1100, 0, 0);
        issue(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 4'b0100, 0, 0);
        issue(32'h0000_0100, 32'h0000_0100, 1'b1, 32'h0000_0000, 4'b0100, 0, 0);
        issue(32'h0100_0000, 32'h0000_0000, 1'b0, 32'h0100_0000, 4'b0000, 0, 0);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 4'b0000, 0, 0);
        issue(32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 4'b1010, 0, 0);

        // Backpressure: hold DONE and wiggle inputs that must be ignored.
        @(negedge clk);
        while (sb.size() != 0) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(32'hDEAD_BEEF, 32'h1000_0000, 1'b0, 32'hEEAD_BEEF, 4'b0010, 0, 0);
        seen_ov = 0;
        for (int i = 0; i < 20 && !seen_ov; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov = 1;
        end
        check("backpressure_out_valid_rose", seen_ov, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            A = $urandom; B = $urandom; SUB = ~SUB; in_valid = ~in_valid;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", in_ready, 1);

        // Back-to-back random ops, in_valid held high.
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ra;
            m = model(ra, rb, rs);
            issue(ra, rb, rs, m.res, m.fl, 1, i > 0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_serial_addsub.md
# byte_serial_addsub

Multi-cycle WIDTH-bit add/subtract unit that processes one SLICE-bit slice per clock through a single ripple slice, then reports the result and arithmetic flags over a valid/ready handshake. It is the area-reduced subtract-capable counterpart to the single-cycle conditional-sum adders. It serves the execute datapath for non-critical address and flag arithmetic (CF/ZF/SF/OF), where latency is traded for one slice of adder hardware.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE
- SLICE, 8, bits computed per cycle; NSLICE = WIDTH/SLICE
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept operands; equals (state==IDLE)
- A  in  WIDTH  minuend/addend
- B  in  WIDTH  subtrahend/addend
- SUB  in  1  0: A+B, 1: A-B
- out_valid  out  1  RES and flags valid
- out_ready  in  1  consumer accepts result
- RES  out  WIDTH  result
- CF  out  1  add: carry out; sub: borrow (= NOT carry out)
- ZF  out  1  RES == 0
- SF  out  1  RES[WIDTH-1]
- OF  out  1  signed overflow

## Operation
- States: IDLE, BUSY, DONE. Slice counter cnt, width ceil(log2(NSLICE)).
- IDLE: in_ready=1. On in_valid&in_ready: latch A, B^{WIDTH{SUB}}, SUB; set carry=SUB; cnt=0; clear RES; go BUSY.
- BUSY: each cycle add slice cnt: {c, s} = Aslice + Bslice + carry. Write s into RES[cnt*SLICE +: SLICE]; carry<=c; cnt<=cnt+1. On the edge with cnt==NSLICE-1, compute flags from the final slice and go DONE.
- Flags, captured on the final BUSY edge: CF = c ^ SUB; SF = MSB of the final sum; OF = carry into MSB XOR carry out of MSB, computed inside the final slice; ZF = (all earlier RES bits == 0) & (final slice == 0). ZF accumulates through a running zero bit, with no WIDTH-wide reduction.
- DONE: out_valid=1. RES/flags are held stable until out_valid&out_ready, then go IDLE.
- in_ready is 0 in BUSY and DONE. Operands presented then are not accepted, and in_valid may stay high.
- A, B and SUB are sampled only at acceptance. Input changes afterwards have no effect.
- Inputs are unsigned/two's-complement; no saturation; RES wraps mod 2^WIDTH.

## Timing
- Reset (async assert, any state): state=IDLE, cnt=0, RES=0, CF=ZF=SF=OF=0, out_valid=0, in_ready=1 while rst_n low and after release. An operation in flight is discarded and produces no output.
- Acceptance at edge k → BUSY for edges k+1..k+NSLICE → out_valid=1 in the cycle after edge k+NSLICE. With defaults, out_valid rises 4 cycles after the acceptance edge.
- If out_ready=1 when out_valid rises, the handshake completes on edge k+NSLICE+1 and in_ready=1 the cycle after. Minimum initiation interval is NSLICE+2 cycles (6 with defaults).
- out_ready low: DONE persists indefinitely with no output change. Dropping out_ready mid-hold is legal.
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.
- NSLICE==1 is legal: a single BUSY cycle.

## Test plan
- Reset mid-op: accept 0x12345678+0x11111111, assert rst_n low at BUSY cnt=2 → out_valid stays 0; RES=0 and flags 0; in_ready=1 after release. Next op 0x5-0x3 → RES=0x00000002, CF=0, ZF=0, SF=0, OF=0.
- Subtract with borrow: SUB=1, A=0x00000000, B=0x00000001 → RES=0xFFFFFFFF, CF=1, SF=1, ZF=0, OF=0; out_valid exactly 4 cycles after acceptance.
- Signed overflow on add: SUB=0, A=0x7FFFFFFF, B=0x00000001 → RES=0x80000000, OF=1, SF=1, CF=0, ZF=0. Signed overflow on subtract: SUB=1, A=0x80000000, B=0x00000001 → RES=0x7FFFFFFF, OF=1, CF=0, SF=0.
- Carry and zero: SUB=0, A=0xFFFFFFFF, B=0x00000001 → RES=0x00000000, CF=1, ZF=1. Also SUB=1, A=B=0xA5A5A5A5 → RES=0, ZF=1, CF=0. Also A=0x00000100, B=0x00000100, SUB=1 → ZF=1; the running-zero bit must not stick.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → RES and flags stable, in_ready=0. Change A/B/in_valid during the hold → no effect. Release → in_ready=1 one cycle later.
- Back-to-back: in_valid held high with 100 random ops and out_ready=1 → each result matches a reference model. Operations complete in order, one result per 6 cycles.
